card_dealer: RTL

//  Consumer of the free-running seed counter and the 2 s timer. Loads the counter value as a

---
 rtl/card_dealer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/card_dealer.sv
// ---------------------------------------------------------------------------
// card_dealer
//   Deals card ranks 1..13 from a 52-card deck without replacement. The
//   random source is a 16-bit Galois LFSR seeded from a free-running counter.
//   A draw rolls LFSR nibbles until one lands on a rank that still has cards
//   left. It falls back to a linear scan when the chosen rank is exhausted or
//   after too many out-of-range nibbles.
//
//   Optional feature: define CARD_DEALER_PAUSE_EN to add a WAIT state after
//   every deal. The dealer stays busy there until the external 2 s timer
//   reports completion through i_TwoSec.
//
// Ports
//   clk_50M      in   system clock
//   i_Reset      in   synchronous reset, active-high
//   i_Seed       in   seed value (SEED_W bits)
//   i_SeedLoad   in   pulse: reload the LFSR from i_Seed
//   i_Draw       in   pulse: request one card (ignored while busy or empty)
//   i_Shuffle    in   pulse: refill the deck, abort any draw in flight
//   i_TwoSec     in   2 s elapsed flag (used only with CARD_DEALER_PAUSE_EN)
//   o_Busy       out  draw in progress
//   o_CardValid  out  one-cycle strobe for o_Card / o_Points
//   o_Card       out  rank 1..13, held until the next deal
//   o_Points     out  A=1, 2..10 face value, J/Q/K=10
//   o_CardsLeft  out  cards remaining 0..52
//   o_DeckEmpty  out  o_CardsLeft == 0
//   o_TimerStart out  drives the timer's active input
// ---------------------------------------------------------------------------
module card_dealer #(
    parameter int SEED_W    = 12,
    parameter int MAX_ROLLS = 8
) (
    input  logic              clk_50M,
    input  logic              i_Reset,
    input  logic [SEED_W-1:0] i_Seed,
    input  logic              i_SeedLoad,
    input  logic              i_Draw,
    input  logic              i_Shuffle,
    input  logic              i_TwoSec,
    output logic              o_Busy,
    output logic              o_CardValid,
    output logic [3:0]        o_Card,
    output logic [3:0]        o_Points,
    output logic [5:0]        o_CardsLeft,
    output logic              o_DeckEmpty,
    output logic              o_TimerStart
);

    typedef enum logic [2:0] {S_IDLE, S_ROLL, S_SCAN, S_DEAL, S_WAIT} state_t;

    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int          ROLL_W    = (MAX_ROLLS > 1) ? $clog2(MAX_ROLLS) : 1;
    localparam logic [ROLL_W-1:0] ROLL_LAST = ROLL_W'(MAX_ROLLS - 1);

    state_t            state_reg, state_next;
    logic [15:0]       lfsr_reg;
    logic [3:0]        rank_reg, rank_next;
    logic [ROLL_W-1:0] roll_cnt_reg, roll_cnt_next;
    logic [3:0]        card_reg;
    logic [5:0]        left_reg;
    logic              empty_reg;
    logic [12:0][2:0]  count;

    logic [15:0] seed_ext;
    logic [15:0] seed_mix;
    logic [3:0]  cand;
    logic        cand_ok;
    logic [2:0]  cand_count;
    logic [2:0]  rank_count;
    logic        deal_fire;

    assign seed_ext   = 16'(i_Seed);
    assign seed_mix   = seed_ext ^ LFSR_INIT;
    assign cand       = lfsr_reg[3:0];
    assign cand_ok    = (cand >= 4'd1) && (cand <= 4'd13);
    assign cand_count = cand_ok ? count[cand - 4'd1] : 3'd0;
    assign rank_count = ((rank_reg >= 4'd1) && (rank_reg <= 4'd13)) ? count[rank_reg - 4'd1] : 3'd0;
    // A shuffle landing on the DEAL cycle discards that card entirely.
    assign deal_fire  = (state_reg == S_DEAL) && !i_Shuffle;

    function automatic logic [3:0] next_rank(input logic [3:0] r);
        return (r == 4'd13) ? 4'd1 : r + 4'd1;
    endfunction

    // ---------------- state register ----------------
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            state_reg    <= S_IDLE;
            rank_reg     <= 4'd0;
            roll_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rank_reg     <= rank_next;
            roll_cnt_reg <= roll_cnt_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next    = state_reg;
        rank_next     = rank_reg;
        roll_cnt_next = roll_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (i_Draw && !empty_reg) begin
                    state_next    = S_ROLL;
                    roll_cnt_next = '0;
                end
            end
            S_ROLL: begin
                if (cand_ok) begin
                    if (cand_count != 3'd0) begin
                        rank_next  = cand;
                        state_next = S_DEAL;
                    end else begin
                        rank_next  = next_rank(cand);
                        state_next = S_SCAN;
                    end
                end else if (roll_cnt_reg == ROLL_LAST) begin
                    rank_next  = 4'd1;
                    state_next = S_SCAN;
                end else begin
                    roll_cnt_next = roll_cnt_reg + ROLL_W'(1);
                end
            end
            S_SCAN: begin
                if (rank_count != 3'd0) state_next = S_DEAL;
                else                    rank_next  = next_rank(rank_reg);
            end
            S_DEAL: begin
`ifdef CARD_DEALER_PAUSE_EN
                state_next = S_WAIT;
`else
                state_next = S_IDLE;
`endif
            end
`ifdef CARD_DEALER_PAUSE_EN
            S_WAIT: begin
                if (i_TwoSec) state_next = S_IDLE;
            end
`endif
            default: state_next = S_IDLE;
        endcase
        if (i_Shuffle) state_next = S_IDLE;
    end

    // ---------------- output logic ----------------
    always_comb begin
        logic [3:0] card_out;
        o_Busy      = (state_reg != S_IDLE);
        o_CardValid = deal_fire && !i_Reset;
        card_out    = o_CardValid ? rank_reg : card_reg;
        o_Card      = card_out;
        o_Points    = (card_out >= 4'd10) ? 4'd10 : card_out;
        o_CardsLeft = left_reg;
        o_DeckEmpty = empty_reg;
`ifdef CARD_DEALER_PAUSE_EN
        o_TimerStart = (state_reg == S_WAIT) && !i_TwoSec;
`else
        o_TimerStart = 1'b0;
`endif
    end

`ifndef CARD_DEALER_PAUSE_EN
    wire unused_two_sec = i_TwoSec;
`endif

    // ---------------- LFSR ----------------
    // A seed load takes priority over the ROLL advance. The XOR with the init
    // value keeps a zero seed from locking the register up.
    always_ff @(posedge clk_50M) begin
        if (i_Reset)
            lfsr_reg <= LFSR_INIT;
        else if (i_SeedLoad)
            lfsr_reg <= (seed_mix == 16'd0) ? LFSR_INIT : seed_mix;
        else if (state_reg == S_ROLL)
            lfsr_reg <= (lfsr_reg >> 1) ^ (lfsr_reg[0] ? LFSR_TAPS : 16'd0);
    end

    // ---------------- deck bookkeeping ----------------
    always_ff @(posedge clk_50M) begin
        if (i_Reset) begin
            card_reg  <= 4'd0;
            left_reg  <= 6'd52;
            empty_reg <= 1'b0;
        end else if (i_Shuffle) begin
            left_reg  <= 6'd52;
            empty_reg <= 1'b0;
        end else if (deal_fire) begin
            card_reg  <= rank_reg;
            left_reg  <= left_reg - 6'd1;
            empty_reg <= (left_reg == 6'd1);
        end
    end

    // Each rank counter is only decremented for a rank that was checked
    // non-zero in ROLL/SCAN, so it cannot underflow.
    genvar gi;
    generate
        for (gi = 0; gi < 13; gi++) begin : g_rank
            logic [2:0] cnt_reg;
            always_ff @(posedge clk_50M) begin
                if (i_Reset || i_Shuffle)
                    cnt_reg <= 3'd4;
                else if (deal_fire && (rank_reg == 4'(gi + 1)))
                    cnt_reg <= cnt_reg - 3'd1;
            end
            assign count[gi] = cnt_reg;
        end
    endgenerate

endmodule
